// File: rtl/fetch_prefetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  // One buffered fetch result: the PC it was fetched from and the returned word.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and decode handshake.
interface fetch_prefetch_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 24
);
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_adr;
  logic [31:0]       imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   inst_pc;

  // Fetch stage side.
  modport master (
    input  redirect, redirect_pc, imem_data, inst_ready,
    output imem_req, imem_adr, inst_valid, inst, inst_pc
  );

  // Environment side: memory, decode and branch resolution.
  modport slave (
    output redirect, redirect_pc, imem_data, inst_ready,
    input  imem_req, imem_adr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_prefetch_fifo.sv
// Show-ahead queue of fetch entries with synchronous flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_prefetch.sv
// PC generator and issue control feeding a prefetch queue in front of a
// 1-cycle synchronous instruction memory.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 24,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  fetch_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            head_valid;
  fetch_entry_t    head, wr_entry;
  logic            pop, issue, write;
  logic [CW:0]     occ;

  // A redirect kills the handshake so the stale head is never consumed.
  assign pop   = head_valid & bus.inst_ready & ~bus.redirect;
  // Slots already committed: queued entries plus the in-flight read, minus the one leaving now.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  // Reset gates the request so the memory port is idle while reset is held.
  assign issue = reset & ~bus.redirect & (occ < (CW+1)'(DEPTH));
  assign write = inflight & ~bus.redirect;

  assign bus.imem_req = issue;
  assign bus.imem_adr = fetch_pc[ADDR_W+1:2];

  // PC advance, in-flight tracking and redirect handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  assign wr_entry = '{pc: inflight_pc, inst: bus.imem_data};

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush      (bus.redirect),
    .wr_en      (write),
    .wr_data    (wr_entry),
    .rd_en      (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? head.inst : NOP_INST;
  assign bus.inst_pc    = head_valid ? head.pc   : '0;

  // Target alignment drops the low redirect bits.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Issue throttling must guarantee a free slot for every returning word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    write |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 24;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
    return ({8'h0, a} ^ 32'h00C0_FFEE) * 32'h9E37_79B1;
  endfunction

  // 1-cycle synchronous read; garbage on idle cycles so stale data is detectable.
  always @(posedge clk) bus.imem_data <= bus.imem_req ? memf(bus.imem_adr) : $urandom;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected queue contents plus the outstanding fetch.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  logic [31:0] mpc = RESET_PC;
  logic [31:0] mifpc = '0;
  bit          minfl = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        q.delete();
        mpc   = RESET_PC;
        minfl = 0;
        chk("m_rst_req",   bus.imem_req,   0);
        chk("m_rst_valid", bus.inst_valid, 0);
        chk("m_rst_inst",  bus.inst,       NOP_INST);
        chk("m_rst_pc",    bus.inst_pc,    0);
      end else begin
        bit          ev, pop, req;
        logic [31:0] e_inst, e_pc;
        ev     = q.size() > 0;
        e_inst = ev ? q[0].inst : NOP_INST;
        e_pc   = ev ? q[0].pc : 32'h0;
        pop    = ev && bus.inst_ready && !bus.redirect;
        req    = !bus.redirect && (q.size() + int'(minfl) - int'(pop) < DEPTH);
        chk("m_valid", bus.inst_valid, ev);
        chk("m_inst",  bus.inst,       e_inst);
        chk("m_pc",    bus.inst_pc,    e_pc);
        chk("m_req",   bus.imem_req,   req);
        if (req) chk("m_adr", bus.imem_adr, mpc[ADDR_W+1:2]);
        if (bus.redirect) begin
          q.delete();
          minfl = 0;
          mpc   = bus.redirect_pc & ~32'h3;
        end else begin
          if (minfl) q.push_back('{mifpc, memf(mifpc[ADDR_W+1:2])});
          if (pop) void'(q.pop_front());
          if (req) begin
            mifpc = mpc;
            mpc   = mpc + 32'd4;
          end
          minfl = req;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously mid-cycle, hold for one edge, release: next cycle is cycle 0.
  task automatic do_reset(input bit check_now);
    reset = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_valid_now", bus.inst_valid, 0);
      chk("rst_inst_now",  bus.inst,       NOP_INST);
      chk("rst_req_now",   bus.imem_req,   0);
      chk("rst_pc_now",    bus.inst_pc,    0);
    end
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    int reqs;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Streaming from reset: addresses 0,1,2.. and pcs 0,4,8.. from cycle 2.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t1_req", bus.imem_req, 1);
      chk("t1_adr", bus.imem_adr, c);
      if (c >= 2) begin
        chk("t1_valid", bus.inst_valid, 1);
        chk("t1_pc",    bus.inst_pc,    4 * (c - 2));
      end else begin
        chk("t1_novalid", bus.inst_valid, 0);
      end
      next_cycle();
    end

    // Stall from cycle 2: exactly DEPTH requests, head held, gapless drain on release.
    do_reset(1'b0);
    reqs = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) bus.inst_ready = 1'b0;
      @(negedge clk);
      reqs += int'(bus.imem_req);
      if (c >= 2) chk("t2_head_pc", bus.inst_pc, 0);
      next_cycle();
    end
    chk("t2_reqs", reqs, DEPTH);
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("t2_refill_req", bus.imem_req, 1);
        chk("t2_refill_adr", bus.imem_adr, 4);
      end
      chk("t2_valid", bus.inst_valid, 1);
      chk("t2_pc",    bus.inst_pc,    4 * k);
      next_cycle();
    end

    // Fill the queue, then reset mid-stream; refetch restarts at RESET_PC.
    bus.inst_ready = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("t6_full_valid", bus.inst_valid, 1);
    chk("t6_full_noreq", bus.imem_req,   0);
    next_cycle();
    bus.inst_ready = 1'b1;
    do_reset(1'b1);

    // Redirect to 0x100 in cycle 5.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_adr", bus.imem_adr, c);
      next_cycle();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    @(negedge clk);
    chk("t3_noreq", bus.imem_req, 0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t3_c6_valid", bus.inst_valid, 0);
    chk("t3_c6_adr",   bus.imem_adr,   24'h40);
    next_cycle();
    @(negedge clk);
    chk("t3_c7_valid", bus.inst_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("t3_c8_pc",   bus.inst_pc, 32'h100);
    chk("t3_c8_inst", bus.inst,    memf(24'h40));
    next_cycle();
    @(negedge clk);
    chk("t3_c9_pc", bus.inst_pc, 32'h104);
    next_cycle();

    // Misaligned redirect target.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h203;
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t4_adr", bus.imem_adr, 24'h80);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t4_pc", bus.inst_pc, 32'h200);
    next_cycle();

    // Redirect together with inst_ready on a full queue.
    bus.inst_ready = 1'b0;
    repeat (6) next_cycle();
    bus.inst_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h400;
    @(negedge clk);
    chk("t5_head_shown", bus.inst_valid, 1);
    chk("t5_noreq",      bus.imem_req,   0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t5_empty", bus.inst_valid, 0);
    chk("t5_adr",   bus.imem_adr,   24'h100);
    next_cycle();

    // Randomized traffic: stalls, redirects (aligned and not), occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bus.inst_ready  = ($urandom_range(9) < 7);
      bus.redirect    = ($urandom_range(19) == 0);
      bus.redirect_pc = $urandom;
      if ($urandom_range(499) == 0) begin
        bus.redirect = 1'b0;
        do_reset(1'b0);
      end else begin
        next_cycle();
      end
    end
    bus.redirect = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-cycle fetch stage: a PC generator plus a DEPTH-entry prefetch queue in front of a synchronous-read instruction memory. Issues one word-aligned fetch per cycle while the queue has room, buffers returned {pc, inst} pairs, and presents them to decode with a valid/ready handshake. Branch/jump redirects, already resolved and merged upstream from b_en/UJ_en/jalr, flush the queue and any in-flight fetch.

## Interface
- XLEN, 32, PC and instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 24, instruction-memory word-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- redirect  input  1  taken branch/jump this cycle
- redirect_pc  input  XLEN  target address
- imem_req  output  1  fetch request this cycle
- imem_adr  output  ADDR_W  word address, fetch_pc[ADDR_W+1:2]
- imem_data  input  32  read data, valid the cycle after the request
- inst_valid  output  1  queue head valid
- inst_ready  input  1  decode accepts head (low = stall)
- inst  output  32  head instruction; 32'h0000_0013 (NOP) when !inst_valid
- inst_pc  output  XLEN  head PC; 0 when !inst_valid

## Operation
- State: fetch_pc, inflight flag, inflight_pc, queue (count 0..DEPTH, rd/wr pointers).
- Reset (reset=0): fetch_pc=RESET_PC, inflight=0, count=0, pointers 0; imem_req=0, inst_valid=0, inst=NOP, inst_pc=0.
- pop = inst_valid & inst_ready & !redirect.
- Issue: imem_req = !redirect & ((count + inflight - pop) < DEPTH); imem_adr from fetch_pc. On issue: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4, inflight<=1; else inflight<=0.
- Response: if inflight & !redirect, write {inflight_pc, imem_data} at wr pointer.
- count_next = count + write - pop; pointers wrap modulo DEPTH; simultaneous write and pop at count=DEPTH or count=0 is legal and counted correctly.
- Redirect: count<=0, pointers<=0, inflight<=0 (response arriving this cycle discarded), fetch_pc<={redirect_pc[XLEN-1:2],2'b00}; no request that cycle; pop suppressed even if inst_ready=1.
- Stall: with inst_ready=0 the head (inst, inst_pc) is held stable; fetching continues until the queue plus in-flight fill DEPTH, then imem_req=0.
- fetch_pc wraps at 2^XLEN silently; address bits above ADDR_W+1 are ignored.
- Queue never overflows: any write must find count<DEPTH (assert).

## Timing
- Out of reset: first request in cycle 0 (first edge after deassert), data written at end of cycle 1, inst_valid=1 in cycle 2.
- Redirect asserted in cycle R: request for target in R+1, inst_valid for target in R+3; no stale instruction visible in R+1..R+2.
- Sustained throughput 1 instruction/cycle with inst_ready=1.
- After stall release, head advances on the same edge as the handshake; refill of the freed slot issues in that same cycle.
- Reset asserted mid-operation clears all state asynchronously; outputs take reset values immediately.

## Structure
- fetch_pkg: fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] inst;}, NOP_INST=32'h0000_0013.
- Sub-module fetch_fifo (DEPTH × fetch_entry_t, flush, show-ahead head, count output); PC/issue logic stays in fetch_prefetch.
- Instruction memory remains external; bench models 1-cycle synchronous read.

## Test plan
- Reset, RESET_PC=0, inst_ready=1: imem_adr 0,1,2,… from cycle 0; inst_pc 0,4,8,… from cycle 2, one per cycle.
- Hold inst_ready=0 from cycle 2: exactly DEPTH=4 requests total, imem_req low afterwards; head stays pc=0; release → pcs 0,4,8,12,16 consecutively with no gap.
- Redirect to 32'h100 in cycle 5 with inst_ready=1: no inst_valid in cycles 6-7; inst_pc=32'h100 in cycle 8; the response from cycle 4's request never appears.
- Redirect to 32'h203 (misaligned): imem_adr=32'h80, inst_pc=32'h200.
- Redirect and inst_ready=1 same cycle with full queue: no pop counted; queue empty next cycle; no overflow assertion.
- Assert reset mid-stream with queue full: inst_valid=0, inst=NOP, imem_req=0 immediately; after release refetch from RESET_PC.
